stream_matrix_transpose: RTL and testbench

Parametrised, streaming successor to the fixed 4x4 switch-based transpose. Accepts a ROWS x COLS matrix one row per beat over a valid/ready handshake. Emits either its transpose, one column per beat, or the unmodified rows. Ping-pong storage lets one matrix drain while the next fills, so back-to-back matrices stream without bubbles. Sits between the coefficient-load path and the NTT/HE datapath.

---
 rtl/stream_matrix_transpose_if.sv | 30 +++
 rtl/stream_matrix_transpose.sv | 115 +++++++++++
 tb/tb_stream_matrix_transpose.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/stream_matrix_transpose_if.sv
// Row-in / beat-out stream bundle for the matrix transpose block.
// The slave modport is the block's view; the master modport is the driver's view.
interface stream_matrix_transpose_if #(
  parameter int WIDTH = 8,
  parameter int ROWS  = 4,
  parameter int COLS  = 4
);
  localparam int MAXD  = (ROWS > COLS) ? ROWS : COLS;
  localparam int OUT_W = MAXD * WIDTH;

  logic                    ctrl;
  logic                    in_valid;
  logic                    in_ready;
  logic [COLS*WIDTH-1:0]   in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUT_W-1:0]        out_data;
  logic                    out_last;
  logic                    out_mode;

  modport slave (
    input  ctrl, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, out_mode
  );

  modport master (
    output ctrl, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_mode
  );
endinterface

// File: rtl/stream_matrix_transpose.sv
// Streaming ROWS x COLS matrix transpose with ping-pong banks.
// One bank fills a row per beat while the other drains a column (transpose)
// or a row (pass-through) per beat, so back-to-back matrices flow without gaps.
module stream_matrix_transpose #(
  parameter int WIDTH = 8,
  parameter int ROWS  = 4,
  parameter int COLS  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  stream_matrix_transpose_if.slave s
);
  localparam int MAXD  = (ROWS > COLS) ? ROWS : COLS;
  localparam int OUT_W = MAXD * WIDTH;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BW    = (MAXD > 1) ? $clog2(MAXD) : 1;

  logic [1:0]       full_reg;
  logic [1:0]       mode_reg;
  logic             wr_sel_reg;
  logic             rd_sel_reg;
  logic [RW-1:0]    wr_row_reg;
  logic [BW-1:0]    rd_beat_reg;

  logic             wr_ok;
  logic             wr_fire;
  logic             wr_last;
  logic             rd_valid;
  logic             rd_fire;
  logic             rd_last;
  logic             cur_mode;
  logic [BW-1:0]    last_beat;
  logic [OUT_W-1:0] bank_beat [2];

  // Ready is forced low during reset so no row is taken into a bank being cleared.
  assign wr_ok     = !rst && !full_reg[wr_sel_reg];
  assign wr_fire   = s.in_valid && wr_ok;
  assign wr_last   = (wr_row_reg == RW'(ROWS - 1));

  assign rd_valid  = full_reg[rd_sel_reg];
  assign cur_mode  = mode_reg[rd_sel_reg];
  assign last_beat = cur_mode ? BW'(COLS - 1) : BW'(ROWS - 1);
  assign rd_last   = (rd_beat_reg == last_beat);
  assign rd_fire   = rd_valid && s.out_ready;

  assign s.in_ready  = wr_ok;
  assign s.out_valid = rd_valid;
  assign s.out_last  = rd_valid && rd_last;
  assign s.out_mode  = cur_mode;
  // Banks are not reset, so the beat is gated to keep the bus X-free when idle.
  assign s.out_data  = rd_valid ? bank_beat[rd_sel_reg] : '0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic [WIDTH-1:0] bank_mem [ROWS][COLS];
    logic [OUT_W-1:0] beat;

    // Capture the incoming row into this bank when it is the write target.
    always_ff @(posedge clk) begin
      if (wr_fire && (wr_sel_reg == 1'(gi))) begin
        for (int j = 0; j < COLS; j++) begin
          bank_mem[wr_row_reg][j] <= s.in_data[j*WIDTH +: WIDTH];
        end
      end
    end

    // Select the current beat: column rd_beat when transposing, row rd_beat otherwise.
    always_comb begin
      beat = '0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (mode_reg[gi]) begin
            if (c == int'(rd_beat_reg)) beat[r*WIDTH +: WIDTH] = bank_mem[r][c];
          end else begin
            if (r == int'(rd_beat_reg)) beat[c*WIDTH +: WIDTH] = bank_mem[r][c];
          end
        end
      end
    end

    assign bank_beat[gi] = beat;
  end

  // Write pointer, read pointer, per-bank full flags and latched modes.
  // Fill and drain always target different banks, so both may update in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_reg    <= '0;
      mode_reg    <= '0;
      wr_sel_reg  <= 1'b0;
      rd_sel_reg  <= 1'b0;
      wr_row_reg  <= '0;
      rd_beat_reg <= '0;
    end else begin
      if (wr_fire) begin
        if (wr_row_reg == '0) mode_reg[wr_sel_reg] <= s.ctrl;
        if (wr_last) begin
          full_reg[wr_sel_reg] <= 1'b1;
          wr_row_reg           <= '0;
          wr_sel_reg           <= !wr_sel_reg;
        end else begin
          wr_row_reg <= wr_row_reg + RW'(1);
        end
      end
      if (rd_fire) begin
        if (rd_last) begin
          full_reg[rd_sel_reg] <= 1'b0;
          rd_beat_reg          <= '0;
          rd_sel_reg           <= !rd_sel_reg;
        end else begin
          rd_beat_reg <= rd_beat_reg + BW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_stream_matrix_transpose.sv
// Bench for stream_matrix_transpose: a 4x4 instance driven by directed and
// random matrices against a queue-based reference, plus a 2x3 directed instance.
module tb_stream_matrix_transpose;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_matrix_transpose_if #(.WIDTH(8), .ROWS(4), .COLS(4)) ifa ();
  stream_matrix_transpose_if #(.WIDTH(8), .ROWS(2), .COLS(3)) ifb ();

  stream_matrix_transpose #(.WIDTH(8), .ROWS(4), .COLS(4)) dut_a (.clk(clk), .rst(rst), .s(ifa));
  stream_matrix_transpose #(.WIDTH(8), .ROWS(2), .COLS(3)) dut_b (.clk(clk), .rst(rst), .s(ifb));

  int errors = 0;
  int checks = 0;

  typedef struct { logic [31:0] data; logic last; logic mode; } beat_t;
  typedef struct { logic ctrl; logic [31:0] data; } row_t;
  typedef struct { logic ctrl; logic [31:0] data; logic last; } vec_t;
  typedef struct { logic [23:0] data; logic last; } vecb_t;

  beat_t       exp_q[$];
  beat_t       cap_q[$];
  row_t        in_q[$];
  logic [7:0]  m_mat [4][4];
  int          m_rows = 0;
  logic        m_ctrl = 1'b0;
  int          npend = 0;
  int          or_policy = 0;
  int          iv_pct = 100;
  logic        held = 1'b0;
  logic [31:0] held_data = '0;
  int          streak = 0, max_streak = 0, stall_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pat_row(input int i);
    logic [31:0] d;
    for (int j = 0; j < 4; j++) d[j*8 +: 8] = 8'(16*i + 10 + j);
    return d;
  endfunction

  task automatic push_matrix(input logic ctrl, input logic rnd);
    row_t r;
    for (int i = 0; i < 4; i++) begin
      r.ctrl = (i == 0) ? ctrl : 1'($urandom);
      r.data = rnd ? $urandom : pat_row(i);
      in_q.push_back(r);
    end
  endtask

  // One clock of the 4x4 instance: drive, then score the handshakes at the coming edge.
  task automatic cycle_a();
    beat_t b;
    logic [31:0] d;
    if (in_q.size() > 0 && $urandom_range(99) < iv_pct) begin
      ifa.in_valid = 1'b1; ifa.in_data = in_q[0].data; ifa.ctrl = in_q[0].ctrl;
    end else begin
      ifa.in_valid = 1'b0; ifa.in_data = $urandom; ifa.ctrl = 1'($urandom);
    end
    ifa.out_ready = (or_policy == 0) ? 1'b1 : (or_policy == 1) ? 1'b0 : 1'($urandom);
    #1;
    if (rst) begin
      check("rst_in_ready", ifa.in_ready, 0);
      exp_q.delete(); in_q.delete(); npend = 0; m_rows = 0; held = 1'b0;
    end else begin
      check("in_ready", ifa.in_ready, (npend < 2));
      check("out_valid", ifa.out_valid, (npend > 0));
      if (!ifa.out_valid) check("idle_out", {ifa.out_last, ifa.out_data}, 0);
      if (held && ifa.out_valid) check("hold_data", ifa.out_data, held_data);
      held = ifa.out_valid && !ifa.out_ready;
      held_data = ifa.out_data;
      if (ifa.out_valid) begin streak++; if (streak > max_streak) max_streak = streak; end
      else streak = 0;
      if (ifa.in_valid && !ifa.in_ready) stall_cnt++;
      if (ifa.out_valid && ifa.out_ready) begin
        if (exp_q.size() == 0) check("spurious_beat", ifa.out_valid, 0);
        else begin
          b = exp_q.pop_front();
          check("beat_data", ifa.out_data, b.data);
          check("beat_last", ifa.out_last, b.last);
          check("beat_mode", ifa.out_mode, b.mode);
          if (b.last) npend--;
          b.data = ifa.out_data; b.last = ifa.out_last; b.mode = ifa.out_mode;
          cap_q.push_back(b);
        end
      end
      if (ifa.in_valid && ifa.in_ready) begin
        if (m_rows == 0) m_ctrl = ifa.ctrl;
        for (int j = 0; j < 4; j++) m_mat[m_rows][j] = ifa.in_data[j*8 +: 8];
        m_rows++;
        void'(in_q.pop_front());
        if (m_rows == 4) begin
          for (int k = 0; k < 4; k++) begin
            for (int e = 0; e < 4; e++) d[e*8 +: 8] = m_ctrl ? m_mat[e][k] : m_mat[k][e];
            b.data = d; b.last = (k == 3); b.mode = m_ctrl;
            exp_q.push_back(b);
          end
          npend++;
          m_rows = 0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while ((in_q.size() > 0 || npend > 0) && n < budget) begin
      cycle_a();
      n++;
    end
    check("drain_done", in_q.size() + npend, 0);
  endtask

  vec_t  tab [8];
  vecb_t tabb [3];

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    tab[0] = '{1'b1, 32'h3A2A1A0A, 1'b0};
    tab[1] = '{1'b1, 32'h3B2B1B0B, 1'b0};
    tab[2] = '{1'b1, 32'h3C2C1C0C, 1'b0};
    tab[3] = '{1'b1, 32'h3D2D1D0D, 1'b1};
    tab[4] = '{1'b0, 32'h0D0C0B0A, 1'b0};
    tab[5] = '{1'b0, 32'h1D1C1B1A, 1'b0};
    tab[6] = '{1'b0, 32'h2D2C2B2A, 1'b0};
    tab[7] = '{1'b0, 32'h3D3C3B3A, 1'b1};
    tabb[0] = '{24'h001A0A, 1'b0};
    tabb[1] = '{24'h001B0B, 1'b0};
    tabb[2] = '{24'h001C0C, 1'b1};

    rst = 1'b1;
    ifa.ctrl = 1'b0; ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.out_ready = 1'b1;
    ifb.ctrl = 1'b0; ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.out_ready = 1'b1;
    @(negedge clk);
    repeat (3) cycle_a();
    rst = 1'b0;
    #1;
    check("reset_out_valid", ifa.out_valid, 0);
    check("reset_out_last", ifa.out_last, 0);
    check("reset_out_mode", ifa.out_mode, 0);
    check("reset_out_data", ifa.out_data, 0);
    check("reset_in_ready", ifa.in_ready, 1);
    check("reset_b_in_ready", ifb.in_ready, 1);
    @(negedge clk);

    // 2x3 transpose: two rows in, three two-element columns out.
    ifb.ctrl = 1'b1;
    for (int r = 0; r < 2; r++) begin
      ifb.in_valid = 1'b1;
      ifb.in_data = (r == 0) ? 24'h0C0B0A : 24'h1C1B1A;
      #1;
      check("b_in_ready", ifb.in_ready, 1);
      @(posedge clk); @(negedge clk);
    end
    ifb.in_valid = 1'b0;
    nb = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1;
      if (ifb.out_valid) begin
        if (nb < 3) begin
          check("b_beat_data", ifb.out_data, tabb[nb].data);
          check("b_beat_last", ifb.out_last, tabb[nb].last);
          check("b_beat_mode", ifb.out_mode, 1);
        end else check("b_spurious", ifb.out_valid, 0);
        nb++;
      end
      @(posedge clk); @(negedge clk);
    end
    check("b_beat_count", nb, 3);

    // Three back-to-back matrices, alternating mode, no bubbles expected.
    cap_q.delete(); streak = 0; max_streak = 0; stall_cnt = 0;
    push_matrix(1'b1, 1'b0); push_matrix(1'b0, 1'b0); push_matrix(1'b1, 1'b0);
    run_idle(100);
    check("b2b_streak", max_streak, 12);
    check("b2b_stalls", stall_cnt, 0);
    check("b2b_beats", cap_q.size(), 12);
    for (int i = 0; i < 8; i++) begin
      if (i < cap_q.size()) begin
        check("tab_data", cap_q[i].data, tab[i].data);
        check("tab_last", cap_q[i].last, tab[i].last);
        check("tab_mode", cap_q[i].mode, tab[i].ctrl);
      end else check("tab_missing", cap_q.size(), 8);
    end

    // Backpressure: both banks fill, input stalls, output held stable.
    or_policy = 1; cap_q.delete();
    push_matrix(1'b1, 1'b1); push_matrix(1'b0, 1'b1); push_matrix(1'b1, 1'b1);
    repeat (18) cycle_a();
    check("bp_in_ready", ifa.in_ready, 0);
    check("bp_out_valid", ifa.out_valid, 1);
    check("bp_rows_left", in_q.size(), 4);
    or_policy = 0;
    run_idle(100);
    check("bp_beats", cap_q.size(), 12);

    // Random traffic with random backpressure.
    or_policy = 2; iv_pct = 60;
    for (int m = 0; m < 20; m++) push_matrix(1'($urandom), 1'b1);
    run_idle(3000);
    or_policy = 0; iv_pct = 100;

    // Reset mid-fill of the second matrix while the first drains.
    push_matrix(1'b1, 1'b1); push_matrix(1'b0, 1'b1);
    repeat (6) cycle_a();
    rst = 1'b1;
    cycle_a();
    rst = 1'b0;
    #1;
    check("rst_mid_out_valid", ifa.out_valid, 0);
    check("rst_mid_in_ready", ifa.in_ready, 1);
    cap_q.delete();
    push_matrix(1'b1, 1'b0);
    run_idle(100);
    check("rst_fresh_beats", cap_q.size(), 4);
    if (cap_q.size() > 0) check("rst_fresh_first", cap_q[0].data, tab[0].data);
    check("exp_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
